// File: rtl/ram_pkg.sv
// Shared constants and types for the single-port RAM arbiter/sequencer.
package ram_pkg;

    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [DW-1:0] INIT_VAL = 4'h0;

    localparam logic CL_A = 1'b0;
    localparam logic CL_B = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Owner tag carried alongside an outstanding read
    typedef struct packed {
        logic vld;
        logic id;
    } rtag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer flips to the other client after every grant.
module rr_arb2
    import ram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_gnt_o,
    output logic b_gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (a_req_i && (!b_req_i || ptr_q == CL_A)) begin
                a_gnt_o = 1'b1;
            end else if (b_req_i) begin
                b_gnt_o = 1'b1;
            end
        end
        if (a_gnt_o) begin
            ptr_d = CL_B;
        end else if (b_gnt_o) begin
            ptr_d = CL_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= CL_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_1port_arb.sv
// Zero-fills a 128x4 single-port RAM, then shares its port between two
// clients with round-robin arbitration and steers read data back by tag.
module ram_1port_arb
    import ram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          init_done,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          enb_q, enb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    rtag_t         tag1_q, tag1_d;
    rtag_t         tag2_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (state_q == ST_RUN),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .a_gnt_o (a_gnt),
        .b_gnt_o (b_gnt)
    );

    // Next state, init sequencing and command issue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enb_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tag1_d  = '0;
        case (state_q)
            ST_INIT: begin
                enb_d   = 1'b1;
                addr_d  = cnt_q;
                wdata_d = INIT_VAL;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
                if (clr_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (a_gnt) begin
                    enb_d      = a_we;
                    addr_d     = a_addr;
                    wdata_d    = a_wdata;
                    tag1_d.vld = !a_we;
                    tag1_d.id  = CL_A;
                end else if (b_gnt) begin
                    enb_d      = b_we;
                    addr_d     = b_addr;
                    wdata_d    = b_wdata;
                    tag1_d.vld = !b_we;
                    tag1_d.id  = CL_B;
                end
                if (clr_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            enb_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            enb_q     <= enb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag1_q;
            a_rdata_q <= a_rdata;
            b_rdata_q <= b_rdata;
        end
    end

    // Read data arrives in the same cycle its tag leaves stage 2; hold it afterwards
    assign a_rvalid  = tag2_q.vld && (tag2_q.id == CL_A);
    assign b_rvalid  = tag2_q.vld && (tag2_q.id == CL_B);
    assign a_rdata   = a_rvalid ? ram_rdata : a_rdata_q;
    assign b_rdata   = b_rvalid ? ram_rdata : b_rdata_q;

    assign init_done = (state_q == ST_RUN);
    assign ram_enb   = enb_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule
